// File: rtl/room_icon_drawer_if.sv
// rtl/room_icon_drawer_if.sv - icon request and VGA pixel bundle between room datapath, drawer and adapter
interface room_icon_drawer_if;
    logic       drawen;
    logic       clearinitsignal;
    logic [7:0] xcoord;
    logic [6:0] ycoord;
    logic [2:0] colour_in;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       plot;
    logic       busy;
    logic       countDone;

    modport master (
        output drawen, clearinitsignal, xcoord, ycoord, colour_in,
        input  vga_x, vga_y, vga_colour, plot, busy, countDone
    );

    modport slave (
        input  drawen, clearinitsignal, xcoord, ycoord, colour_in,
        output vga_x, vga_y, vga_colour, plot, busy, countDone
    );
endinterface

// File: rtl/room_icon_drawer.sv
// rtl/room_icon_drawer.sv - sweeps an icon rectangle or the full screen, one pixel per cycle
module room_icon_drawer #(
    parameter int ICON_W   = 8,
    parameter int ICON_H   = 8,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic               clock,
    input  logic               reset,
    room_icon_drawer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, DRAW, CLEAR, DONE} state_t;

    localparam logic [7:0] ICON_X_LAST = 8'(ICON_W - 1);
    localparam logic [6:0] ICON_Y_LAST = 7'(ICON_H - 1);
    localparam logic [7:0] SCR_X_LAST  = 8'(SCREEN_W - 1);
    localparam logic [6:0] SCR_Y_LAST  = 7'(SCREEN_H - 1);
    localparam logic [8:0] SCR_W9      = 9'(SCREEN_W);
    localparam logic [7:0] SCR_H8      = 8'(SCREEN_H);

    state_t     state_q, state_d;
    logic [7:0] cx_q, cx_d, bx_q, bx_d;
    logic [6:0] cy_q, cy_d, by_q, by_d;
    logic [2:0] col_q, col_d;

    logic [8:0] sum_x;
    logic [7:0] sum_y;
    logic [7:0] vga_x_c;
    logic [6:0] vga_y_c;
    logic [2:0] vga_colour_c;
    logic       plot_c, busy_c, done_c;

    // Wide sums so off-screen pixels are detected rather than wrapped onto the screen
    assign sum_x = {1'b0, bx_q} + {1'b0, cx_q};
    assign sum_y = {1'b0, by_q} + {1'b0, cy_q};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cx_q    <= '0;
            cy_q    <= '0;
            bx_q    <= '0;
            by_q    <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            col_q   <= col_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        bx_d         = bx_q;
        by_d         = by_q;
        col_d        = col_q;
        vga_x_c      = '0;
        vga_y_c      = '0;
        vga_colour_c = '0;
        plot_c       = 1'b0;
        busy_c       = 1'b0;
        done_c       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.clearinitsignal) begin
                    state_d = CLEAR;
                    cx_d    = '0;
                    cy_d    = '0;
                end else if (bus.drawen) begin
                    state_d = DRAW;
                    bx_d    = bus.xcoord;
                    by_d    = bus.ycoord;
                    col_d   = bus.colour_in;
                    cx_d    = '0;
                    cy_d    = '0;
                end
            end
            DRAW: begin
                busy_c       = 1'b1;
                vga_x_c      = sum_x[7:0];
                vga_y_c      = sum_y[6:0];
                vga_colour_c = col_q;
                plot_c       = (sum_x < SCR_W9) && (sum_y < SCR_H8);
                if (bus.clearinitsignal) begin
                    state_d = CLEAR;
                    cx_d    = '0;
                    cy_d    = '0;
                end else if (cx_q == ICON_X_LAST) begin
                    cx_d = '0;
                    if (cy_q == ICON_Y_LAST) begin
                        cy_d    = '0;
                        state_d = DONE;
                    end else begin
                        cy_d = cy_q + 7'd1;
                    end
                end else begin
                    cx_d = cx_q + 8'd1;
                end
            end
            CLEAR: begin
                busy_c  = 1'b1;
                vga_x_c = cx_q;
                vga_y_c = cy_q;
                plot_c  = 1'b1;
                if (cx_q == SCR_X_LAST) begin
                    cx_d = '0;
                    if (cy_q == SCR_Y_LAST) begin
                        cy_d    = '0;
                        state_d = DONE;
                    end else begin
                        cy_d = cy_q + 7'd1;
                    end
                end else begin
                    cx_d = cx_q + 8'd1;
                end
            end
            DONE: begin
                done_c  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.vga_x      = vga_x_c;
    assign bus.vga_y      = vga_y_c;
    assign bus.vga_colour = vga_colour_c;
    assign bus.plot       = plot_c;
    assign bus.busy       = busy_c;
    assign bus.countDone  = done_c;
endmodule

// File: doc/room_icon_drawer.md
Name: room_icon_drawer

Overview:
- Downstream VGA stage of the room controller/datapath pair.
- Takes a latched icon origin (xcoord/ycoord) and colour, and emits one pixel per cycle to the VGA adapter, sweeping an ICON_W x ICON_H rectangle.
- Also performs a full-screen clear sweep.
- Returns a one-cycle countDone pulse to the control path when a sweep finishes.

Parameters:
- ICON_W, 8, icon width in pixels (1..32)
- ICON_H, 8, icon height in pixels (1..32)
- SCREEN_W, 160, screen width in pixels
- SCREEN_H, 120, screen height in pixels

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high; one clock, synchronous active-high reset
- drawen  in  1  start icon sweep (sampled only in IDLE)
- clearinitsignal  in  1  start/force full-screen clear sweep
- xcoord  in  8  icon origin x (top-left)
- ycoord  in  7  icon origin y (top-left)
- colour_in  in  3  RGB icon colour
- vga_x  out  8  pixel x to VGA adapter
- vga_y  out  7  pixel y to VGA adapter
- vga_colour  out  3  pixel colour
- plot  out  1  pixel write strobe
- busy  out  1  high while in DRAW or CLEAR
- countDone  out  1  one-cycle pulse: sweep complete

Behaviour:
- Reset: state IDLE. vga_x, vga_y, vga_colour, plot, busy and countDone are all 0. Counters and latched origin/colour are 0.
- Reset has priority over all inputs in any state. Reset mid-sweep aborts with no countDone.
- States: IDLE, DRAW, CLEAR, DONE.

IDLE:
- clearinitsignal=1 -> CLEAR. Counters cleared. This has priority over drawen in the same cycle.
- else drawen=1 -> DRAW. Latch xcoord, ycoord, colour_in; counters cx=cy=0.
- All outputs 0 in IDLE.

DRAW:
- Outputs are registered. If the start is sampled at edge T, pixel k (row-major: cx fastest, then cy) appears in cycle T+1+k, k=0..ICON_W*ICON_H-1.
- vga_x = bx+cx and vga_y = by+cy, with sums formed at 9/8 bits.
- plot=1 unless bx+cx >= SCREEN_W or by+cy >= SCREEN_H. A clipped pixel gives plot=0 with vga_x/vga_y showing the truncated sum, but the counters still advance, so sweep length is fixed.
- cx wraps ICON_W-1 -> 0 and increments cy.
- After the last pixel -> DONE.
- drawen is ignored while busy.
- clearinitsignal=1 during DRAW aborts the draw: the next state is CLEAR, counters reset, no countDone for the aborted draw.

CLEAR:
- Sweeps x=0..SCREEN_W-1, y=0..SCREEN_H-1 row-major, colour 0, plot=1: 19200 cycles at default parameters.
- Re-asserting clearinitsignal during CLEAR is ignored; the sweep is not restarted.
- After the last pixel -> DONE.

DONE:
- Exactly one cycle: countDone=1, plot=0, busy=0, then IDLE.
- A drawen present during DONE is not accepted. It must be held or re-asserted in IDLE.

Other rules:
- busy=1 exactly in DRAW and CLEAR.
- Sweep latency from start edge to countDone: ICON_W*ICON_H+1 cycles for DRAW, SCREEN_W*SCREEN_H+1 cycles for CLEAR.
- Origin and colour inputs may change freely after the start edge; the latched values are used.

Test Plan:
- Reset then idle 10 cycles -> plot=0, busy=0, countDone=0 throughout.
- xcoord=20, ycoord=30, colour_in=3'b100, drawen pulse -> 64 plots:
  - first pixel (20,30), eighth (27,30), ninth (21,31)? No: ninth is (20,31); last (27,37), colour 100 on all;
  - countDone high one cycle, 65 cycles after the start edge.
- xcoord=156, ycoord=117 draw -> 64 cycles busy. plot=1 only for x 156..159 and y 117..119 (12 pixels); countDone still at cycle 65.
- clearinitsignal pulse from IDLE -> 19200 plots, colour 0, covering (0,0)..(159,119); countDone at cycle 19201.
- drawen at cycle T, clearinitsignal at T+10 -> draw outputs stop after 10 pixels. A CLEAR sweep from (0,0) follows, and exactly one countDone occurs, at the end of the clear.
- drawen and clearinitsignal together in IDLE -> CLEAR taken. reset asserted mid-CLEAR -> next cycle all outputs 0, no countDone.
